uart_rx_timing: RTL and testbench
=================================

# uart_rx_timing

Parametrised receive-side timing engine for the UART receiver: synchronises the raw serial line, detects and validates the start bit, and generates one mid-bit sample strobe per frame bit with a majority-voted bit value. Supports configurable data width, parity and stop bits, and flags false starts, parity errors and framing errors. It sits between the RXD pin and the receive shift register / framer, which consumes the BCLK/SBIT/BITIDX stream and the BREAK end-of-frame pulse.

## Interface
- SCYCLE, 50_000_000, system clock frequency in Hz
- BAUDRATE, 9600, line rate in bit/s; BDR = SCYCLE/BAUDRATE (integer division), MID = BDR/2 - 1; elaboration fails if BDR < 8
- DATA_BITS, 8, data bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2; NBITS = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-low reset
- RXD  in  1  asynchronous serial line, idle high
- ENABLE  in  1  1 = receiver armed; 0 = hold/abort
- BCLK  out  1  one-cycle pulse: mid-bit sample valid
- SBIT  out  1  majority-voted bit value, valid with BCLK, held until the next BCLK
- BITIDX  out  4  frame bit index of the current bit (0 = start, 1..DATA_BITS = data LSB first, then parity, then stop)
- BUSY  out  1  frame in progress
- BREAK  out  1  one-cycle pulse at end of the last stop bit
- FALSE_START  out  1  one-cycle pulse: start bit rejected
- PAR_ERR  out  1  one-cycle pulse with the parity bit's BCLK on mismatch
- FRAME_ERR  out  1  one-cycle pulse with any stop bit's BCLK when the stop bit samples 0

## Operation
- RXD passes through a 2-flop synchroniser (rx_s); both flops reset to 1.
- Three-sample shift register on rx_s, captured at BCNT = MID-2, MID-1, MID; vote = majority of the three.
- States: IDLE, START, BITS.
- IDLE: BCNT = 0, BITIDX = 0. If ENABLE=1 and rx_s=0 in a cycle (cycle F): BCNT<=0, go to START.
- START: BCNT increments. At BCNT=MID: vote=1 -> FALSE_START pulse, go to IDLE, no BCLK. vote=0 -> BCLK with SBIT=0, BITIDX=0. At BCNT=BDR-1: BCNT<=0, BITIDX<=1, go to BITS.
- BITS: BCNT counts 0..BDR-1 and wraps. At MID: BCLK, SBIT=vote; data votes XOR-accumulate into parity; parity bit checked (odd: XOR of data+parity must be 1; even: must be 0), mismatch -> PAR_ERR; stop bit with vote=0 -> FRAME_ERR (framing continues to the end). At BCNT=BDR-1: if BITIDX=NBITS-1 -> BREAK pulse, go to IDLE; otherwise BITIDX increments.
- ENABLE=0 in START/BITS: immediate abort to IDLE on the next edge, BCNT=0, no BREAK, no error pulses.
- The parity accumulator clears on entry to START.
- RESET=0 (any state, including mid-frame): next edge gives state IDLE, BCNT=0, BITIDX=0, SBIT=1, BCLK=BUSY=BREAK=FALSE_START=PAR_ERR=FRAME_ERR=0, and the synchroniser at 1.

## Timing
- All outputs are registered; each pulse asserts in the cycle after its counter condition.
- RXD falling edge to cycle F: 2 cycles (synchroniser).
- Bit k BCLK: cycle F+2+MID+k*BDR, for k = 0..NBITS-1.
- FALSE_START: cycle F+2+MID. BUSY is high from F+1 and drops in the FALSE_START cycle.
- BREAK: cycle F+1+NBITS*BDR. BUSY is high F+1..F+NBITS*BDR and is 0 in the BREAK cycle.
- Back-to-back frames: IDLE is active in the BREAK cycle. A start edge sampled then is accepted, giving zero dead time.
- Error pulses coincide exactly with the BCLK of the offending bit.

## Test plan
- SCYCLE=160, BAUDRATE=10 (BDR=16, MID=7), 8N1, send 0x55 -> 10 BCLKs at 16-cycle spacing, SBIT sequence 0,1,0,1,0,1,0,1,0,1, BITIDX 0..9. BREAK 1 cycle at F+161. No error pulses.
- Same config, RXD low pulse of 4 cycles -> FALSE_START at F+9, no BCLK, BUSY back to 0, and a following valid frame is received correctly.
- 8E1, send 0xA3 with parity bit 1 (wrong; correct parity is 0) -> PAR_ERR coincident with the BITIDX=9 BCLK. With correct parity 0 -> no PAR_ERR.
- 7O2, second stop bit driven 0 -> FRAME_ERR with the BITIDX=10 BCLK only. BREAK still at F+1+11*16.
- Single-cycle glitch (RXD=1 for 1 cycle at BCNT=MID-1 of a data bit 0) -> vote keeps SBIT=0.
- RESET=0 asserted at BITIDX=4, and separately ENABLE=0 at BITIDX=4 -> IDLE next cycle, all outputs at reset values, no BREAK. A new frame afterwards is received correctly.

Source files
------------

// File: rtl/uart_rx_timing.sv
// uart_rx_timing
//   Receive-side timing engine for the UART receiver. Synchronises the raw
//   serial line, validates the start bit and emits one mid-bit sample strobe
//   per frame bit. Each strobe carries a majority-voted bit value. It also
//   flags false starts, parity errors and framing errors.
//
// Ports
//   clk_i           system clock, all logic on the rising edge
//   reset_ni        synchronous, active-low reset
//   rxd_i           asynchronous serial line, idle high
//   enable_i        1 = receiver armed, 0 = hold / abort the current frame
//   bclk_o          one-cycle pulse: mid-bit sample valid
//   sbit_o          voted bit value, valid with bclk_o, held until the next strobe
//   bitidx_o        frame bit index (0 start, 1..DATA_BITS data, parity, stop)
//   busy_o          frame in progress
//   break_o         one-cycle pulse at the end of the last stop bit
//   false_start_o   one-cycle pulse: start bit rejected
//   par_err_o       one-cycle pulse with the parity bit's strobe on mismatch
//   frame_err_o     one-cycle pulse with a stop bit's strobe when it samples 0
module uart_rx_timing #(
  parameter int SCYCLE    = 50_000_000,
  parameter int BAUDRATE  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rxd_i,
  input  logic       enable_i,
  output logic       bclk_o,
  output logic       sbit_o,
  output logic [3:0] bitidx_o,
  output logic       busy_o,
  output logic       break_o,
  output logic       false_start_o,
  output logic       par_err_o,
  output logic       frame_err_o
);

  localparam int BDR   = SCYCLE / BAUDRATE;
  localparam int MID   = BDR / 2 - 1;
  localparam int PBIT  = (PARITY != 0) ? 1 : 0;
  localparam int NBITS = 1 + DATA_BITS + PBIT + STOP_BITS;
  localparam int CW    = $clog2(BDR);

  localparam logic [CW-1:0] MID_C     = CW'(MID);
  localparam logic [CW-1:0] MIDM1_C   = CW'(MID - 1);
  localparam logic [CW-1:0] MIDM2_C   = CW'(MID - 2);
  localparam logic [CW-1:0] LAST_C    = CW'(BDR - 1);
  localparam logic [3:0]    LASTDAT_C = 4'(DATA_BITS);
  localparam logic [3:0]    PARIDX_C  = 4'(DATA_BITS + 1);
  localparam logic [3:0]    STOPIDX_C = 4'(1 + DATA_BITS + PBIT);
  localparam logic [3:0]    LASTIDX_C = 4'(NBITS - 1);

  // Three samples straddling mid-bit need at least 8 clocks per bit.
  if (BDR < 8) begin : g_bad_bdr
    $error("uart_rx_timing: SCYCLE/BAUDRATE must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_frame
    $error("uart_rx_timing: unsupported frame format");
  end

  typedef enum logic [1:0] {IDLE, START, BITS} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [3:0]    bitidx_q, bitidx_d;
  logic          sync1_q, sync2_q;
  logic [1:0]    samp_q, samp_d;
  logic          par_q, par_d;
  logic          sbit_q, sbit_d;
  logic          bclk_q, bclk_d;
  logic          busy_q, busy_d;
  logic          brk_q, brk_d;
  logic          fs_q, fs_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          rx_s;
  logic          vote;

  assign rx_s = sync2_q;

  // The third sample is the live synchronised line at BCNT = MID.
  // The earlier two come from the shift register.
  assign vote = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s) | (samp_q[0] & rx_s);

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      bcnt_q   <= '0;
      bitidx_q <= '0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      samp_q   <= 2'b11;
      par_q    <= 1'b0;
      sbit_q   <= 1'b1;
      bclk_q   <= 1'b0;
      busy_q   <= 1'b0;
      brk_q    <= 1'b0;
      fs_q     <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      bitidx_q <= bitidx_d;
      sync1_q  <= rxd_i;
      sync2_q  <= sync1_q;
      samp_q   <= samp_d;
      par_q    <= par_d;
      sbit_q   <= sbit_d;
      bclk_q   <= bclk_d;
      busy_q   <= busy_d;
      brk_q    <= brk_d;
      fs_q     <= fs_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    bitidx_d = bitidx_q;
    samp_d   = samp_q;
    par_d    = par_q;
    sbit_d   = sbit_q;
    busy_d   = busy_q;
    bclk_d   = 1'b0;
    brk_d    = 1'b0;
    fs_d     = 1'b0;
    perr_d   = 1'b0;
    ferr_d   = 1'b0;

    if (state_q != IDLE &&
        (bcnt_q == MIDM2_C || bcnt_q == MIDM1_C || bcnt_q == MID_C)) begin
      samp_d = {samp_q[0], rx_s};
    end

    case (state_q)
      IDLE: begin
        bcnt_d   = '0;
        bitidx_d = '0;
        busy_d   = 1'b0;
        if (enable_i && !rx_s) begin
          state_d = START;
          busy_d  = 1'b1;
          par_d   = 1'b0;
        end
      end
      START: begin
        bcnt_d = bcnt_q + CW'(1);
        if (bcnt_q == MID_C) begin
          if (vote) begin
            fs_d    = 1'b1;
            state_d = IDLE;
            busy_d  = 1'b0;
            bcnt_d  = '0;
          end else begin
            bclk_d = 1'b1;
            sbit_d = 1'b0;
          end
        end else if (bcnt_q == LAST_C) begin
          bcnt_d   = '0;
          bitidx_d = 4'd1;
          state_d  = BITS;
        end
      end
      BITS: begin
        bcnt_d = bcnt_q + CW'(1);
        if (bcnt_q == MID_C) begin
          bclk_d = 1'b1;
          sbit_d = vote;
          if (bitidx_q <= LASTDAT_C) begin
            par_d = par_q ^ vote;
          end
          // Odd parity wants an odd count of ones over data + parity.
          if (PARITY != 0 && bitidx_q == PARIDX_C) begin
            perr_d = (PARITY == 1) ? ~(par_q ^ vote) : (par_q ^ vote);
          end
          if (bitidx_q >= STOPIDX_C && !vote) begin
            ferr_d = 1'b1;
          end
        end
        if (bcnt_q == LAST_C) begin
          bcnt_d = '0;
          if (bitidx_q == LASTIDX_C) begin
            brk_d    = 1'b1;
            state_d  = IDLE;
            busy_d   = 1'b0;
            bitidx_d = '0;
          end else begin
            bitidx_d = bitidx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Dropping enable mid-frame discards the frame silently.
    if (state_q != IDLE && !enable_i) begin
      state_d  = IDLE;
      bcnt_d   = '0;
      bitidx_d = '0;
      sbit_d   = 1'b1;
      busy_d   = 1'b0;
      bclk_d   = 1'b0;
      brk_d    = 1'b0;
      fs_d     = 1'b0;
      perr_d   = 1'b0;
      ferr_d   = 1'b0;
    end
  end

  assign bclk_o        = bclk_q;
  assign sbit_o        = sbit_q;
  assign bitidx_o      = bitidx_q;
  assign busy_o        = busy_q;
  assign break_o       = brk_q;
  assign false_start_o = fs_q;
  assign par_err_o     = perr_q;
  assign frame_err_o   = ferr_q;

endmodule

// File: tb/tb_uart_rx_timing.sv
// tb_uart_rx_timing
//   Drives three receivers (8N1, 8E1, 7O2 at 16 clocks per bit) with directed
//   and random line waveforms. Every output pulse is compared against a
//   frame-level reference model computed from the line waveform.
module tb_uart_rx_timing;

  localparam int BDR        = 16;
  localparam int MID        = 7;
  localparam int SNAP_RESET = 512;

  typedef struct {
    int cyc;
    int flags;
  } event_t;

  logic       clock = 1'b0;
  logic       resetN;
  logic       enable;
  logic       rxd [3];
  logic       bclkW [3];
  logic       sbitW [3];
  logic [3:0] bitidxW [3];
  logic       busyW [3];
  logic       breakW [3];
  logic       fsW [3];
  logic       perrW [3];
  logic       ferrW [3];

  int     cyc = 0;
  int     checkCount = 0;
  int     passCount = 0;
  bit     logActive = 1'b0;
  logic   wave [$];
  event_t gotEv [$];
  event_t expEv [$];
  bit     busyExp [];

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  uart_rx_timing #(.SCYCLE(160), .BAUDRATE(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut8n1 (
    .clk_i(clock), .reset_ni(resetN), .rxd_i(rxd[0]), .enable_i(enable),
    .bclk_o(bclkW[0]), .sbit_o(sbitW[0]), .bitidx_o(bitidxW[0]), .busy_o(busyW[0]),
    .break_o(breakW[0]), .false_start_o(fsW[0]), .par_err_o(perrW[0]), .frame_err_o(ferrW[0])
  );

  uart_rx_timing #(.SCYCLE(160), .BAUDRATE(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut8e1 (
    .clk_i(clock), .reset_ni(resetN), .rxd_i(rxd[1]), .enable_i(enable),
    .bclk_o(bclkW[1]), .sbit_o(sbitW[1]), .bitidx_o(bitidxW[1]), .busy_o(busyW[1]),
    .break_o(breakW[1]), .false_start_o(fsW[1]), .par_err_o(perrW[1]), .frame_err_o(ferrW[1])
  );

  uart_rx_timing #(.SCYCLE(160), .BAUDRATE(10), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut7o2 (
    .clk_i(clock), .reset_ni(resetN), .rxd_i(rxd[2]), .enable_i(enable),
    .bclk_o(bclkW[2]), .sbit_o(sbitW[2]), .bitidx_o(bitidxW[2]), .busy_o(busyW[2]),
    .break_o(breakW[2]), .false_start_o(fsW[2]), .par_err_o(perrW[2]), .frame_err_o(ferrW[2])
  );

  // Frame format of each receiver instance.
  function automatic int dataBits(input int d);
    return (d == 2) ? 7 : 8;
  endfunction

  function automatic int parityMode(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 1);
  endfunction

  function automatic int stopBits(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  function automatic int frameBits(input int d);
    return 1 + dataBits(d) + ((parityMode(d) != 0) ? 1 : 0) + stopBits(d);
  endfunction

  function automatic int packEvent(input int d, input int bclk, input int brk, input int fs,
                                   input int perr, input int ferr, input int idx, input int sbit);
    return d * 2048 + bclk * 1024 + brk * 512 + fs * 256 + perr * 128 + ferr * 64 + idx * 2 + sbit;
  endfunction

  function automatic event_t mkEvent(input int c, input int f);
    event_t e;
    e.cyc   = c;
    e.flags = f;
    return e;
  endfunction

  function automatic int snapshot(input int d);
    return int'(bclkW[d]) * 1024 + int'(sbitW[d]) * 512 + int'(busyW[d]) * 256 +
           int'(bitidxW[d]) * 16 + int'(breakW[d]) * 8 + int'(fsW[d]) * 4 +
           int'(perrW[d]) * 2 + int'(ferrW[d]);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  // Log every output pulse of every receiver.
  always @(negedge clock) begin
    if (logActive) begin
      for (int d = 0; d < 3; d++) begin
        if (bclkW[d] || breakW[d] || fsW[d] || perrW[d] || ferrW[d]) begin
          gotEv.push_back(mkEvent(cyc, packEvent(d, int'(bclkW[d]), int'(breakW[d]), int'(fsW[d]),
                                                 int'(perrW[d]), int'(ferrW[d]),
                                                 bclkW[d] ? int'(bitidxW[d]) : 0,
                                                 bclkW[d] ? int'(sbitW[d]) : 0)));
        end
      end
    end
  end

  // Line level wave[i] appears on the synchronised line two cycles later.
  // Outside the wave the line idles high.
  function automatic int waveAt(input int i);
    if (i < 0 || i >= wave.size()) return 1;
    return int'(wave[i]);
  endfunction

  function automatic int vote3(input int c);
    int s;
    s = waveAt(c - 1) + waveAt(c) + waveAt(c + 1);
    return (s >= 2) ? 1 : 0;
  endfunction

  // Reference model: walks the waveform frame by frame and lists the pulses
  // and busy cycles the receiver should produce.
  // All cycles are relative to the first driven wave sample.
  task automatic buildExpected(input int d, input int xBase, input int cutoff, input int total);
    int ready, t, fRel, nb, ones, v, pIdx, stopIdx, endRel, c, perr, ferr;
    expEv.delete();
    busyExp = new[total];
    foreach (busyExp[i]) busyExp[i] = 1'b0;
    nb      = frameBits(d);
    pIdx    = (parityMode(d) != 0) ? dataBits(d) + 1 : -1;
    stopIdx = 1 + dataBits(d) + ((parityMode(d) != 0) ? 1 : 0);
    ready   = 0;
    forever begin
      t = ready;
      while (t < wave.size() && wave[t] != 1'b0) t++;
      if (t >= wave.size()) break;
      fRel = t + 2;
      if (cutoff >= 0 && fRel >= cutoff) break;
      if (vote3(t + MID) == 1) begin
        c = fRel + 2 + MID;
        if (cutoff < 0 || c <= cutoff) expEv.push_back(mkEvent(xBase + c, packEvent(d, 0, 0, 1, 0, 0, 0, 0)));
        endRel = fRel + 1 + MID;
        ready  = t + MID + 2;
      end else begin
        ones = 0;
        for (int k = 0; k < nb; k++) begin
          v    = vote3(t + k * BDR + MID);
          perr = 0;
          ferr = 0;
          if (k >= 1 && k <= dataBits(d)) ones += v;
          if (k == pIdx) begin
            ones += v;
            if (parityMode(d) == 1) perr = (ones % 2 == 0) ? 1 : 0;
            else perr = (ones % 2 == 1) ? 1 : 0;
          end
          if (k >= stopIdx && v == 0) ferr = 1;
          c = fRel + 2 + MID + k * BDR;
          if (cutoff < 0 || c <= cutoff) expEv.push_back(mkEvent(xBase + c, packEvent(d, 1, 0, 0, perr, ferr, k, v)));
        end
        c = fRel + 1 + nb * BDR;
        if (cutoff < 0 || c <= cutoff) expEv.push_back(mkEvent(xBase + c, packEvent(d, 0, 1, 0, 0, 0, 0, 0)));
        endRel = fRel + nb * BDR;
        ready  = t + 1 + nb * BDR;
      end
      for (int i = fRel + 1; i <= endRel; i++) begin
        if (i < total && (cutoff < 0 || i <= cutoff)) busyExp[i] = 1'b1;
      end
    end
  endtask

  task automatic addIdle(input int n);
    repeat (n) wave.push_back(1'b1);
  endtask

  task automatic addBit(input int b);
    repeat (BDR) wave.push_back(b != 0);
  endtask

  task automatic addFrame(input int d, input int data, input int badPar, input int stopMask);
    int p;
    p = 0;
    addBit(0);
    for (int i = 0; i < dataBits(d); i++) begin
      addBit((data >> i) & 1);
      p = p ^ ((data >> i) & 1);
    end
    if (parityMode(d) != 0) addBit(((parityMode(d) == 1) ? (p ^ 1) : p) ^ (badPar & 1));
    for (int s = 0; s < stopBits(d); s++) addBit(((stopMask >> s) & 1) ? 0 : 1);
  endtask

  // Plays the current waveform into receiver d and compares its pulses with
  // the model. abortKind 1 drops enable, 2 pulls reset, at relative cycle abortRel.
  task automatic applyStimulus(input string name, input int d, input int abortKind, input int abortRel);
    int xBase, total, busyErr, cutoff, n;
    busyErr = 0;
    total   = wave.size() + 60;
    cutoff  = (abortKind != 0) ? abortRel : -1;
    @(negedge clock);
    xBase = cyc;
    buildExpected(d, xBase, cutoff, total);
    gotEv.delete();
    logActive = 1'b1;
    for (int t = 0; t < total; t++) begin
      if (busyW[d] != busyExp[t]) busyErr++;
      if (abortKind != 0 && t == abortRel) checkOutput({name, " bitidx at abort"}, int'(bitidxW[d]), 4);
      if (abortKind != 0 && t == abortRel + 1) checkOutput({name, " outputs after abort"}, snapshot(d), SNAP_RESET);
      if (abortKind != 0 && t >= abortRel) rxd[d] = 1'b1;
      else rxd[d] = (t < wave.size()) ? wave[t] : 1'b1;
      enable = !(abortKind == 1 && t >= abortRel && t < abortRel + 4);
      resetN = !(abortKind == 2 && t >= abortRel && t < abortRel + 4);
      @(negedge clock);
    end
    logActive = 1'b0;
    checkOutput({name, " event count"}, gotEv.size(), expEv.size());
    n = (gotEv.size() < expEv.size()) ? gotEv.size() : expEv.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s ev%0d cycle", name, i), gotEv[i].cyc - xBase, expEv[i].cyc - xBase);
      checkOutput($sformatf("%s ev%0d flags", name, i), gotEv[i].flags, expEv[i].flags);
    end
    checkOutput({name, " busy mismatching cycles"}, busyErr, 0);
  endtask

  initial begin
    int s, n, idx;
    resetN = 1'b0;
    enable = 1'b1;
    for (int d = 0; d < 3; d++) rxd[d] = 1'b1;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 3; d++) checkOutput($sformatf("reset state dut%0d", d), snapshot(d), SNAP_RESET);
    resetN = 1'b1;
    repeat (5) @(negedge clock);

    wave.delete(); addIdle(5); addFrame(0, 'h55, 0, 0);
    applyStimulus("8N1 0x55", 0, 0, 0);

    wave.delete(); addIdle(5); repeat (4) wave.push_back(1'b0); addIdle(30);
    addFrame(0, int'($urandom_range(0, 255)), 0, 0);
    applyStimulus("false start", 0, 0, 0);

    wave.delete(); addIdle(5); addFrame(1, 'hA3, 1, 0); addIdle(10); addFrame(1, 'hA3, 0, 0);
    applyStimulus("8E1 0xA3", 1, 0, 0);

    wave.delete(); addIdle(5); addFrame(2, int'($urandom_range(0, 127)), 0, 2);
    applyStimulus("7O2 stop2 low", 2, 0, 0);

    wave.delete(); addIdle(5); s = wave.size();
    addFrame(0, int'($urandom_range(0, 127)) * 2, 0, 0);
    wave[s + BDR + MID] = 1'b1;
    applyStimulus("glitch", 0, 0, 0);

    for (int kind = 1; kind <= 2; kind++) begin
      wave.delete(); addIdle(5); addFrame(0, int'($urandom_range(0, 255)), 0, 0);
      applyStimulus($sformatf("abort kind%0d", kind), 0, kind, 5 + 2 + 1 + 4 * BDR + int'($urandom_range(0, BDR - 1)));
      wave.delete(); addIdle(3); addFrame(0, int'($urandom_range(0, 255)), 0, 0);
      applyStimulus($sformatf("after abort kind%0d", kind), 0, 0, 0);
    end

    for (int r = 0; r < 12; r++) begin
      wave.delete();
      addIdle(int'($urandom_range(1, 20)));
      n = int'($urandom_range(1, 3));
      for (int f = 0; f < n; f++) begin
        addFrame(r % 3, int'($urandom), ($urandom_range(0, 3) == 0) ? 1 : 0,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
        addIdle(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40)));
      end
      repeat (int'($urandom_range(0, 2))) begin
        idx = int'($urandom_range(0, wave.size() - 1));
        wave[idx] = ~wave[idx];
      end
      applyStimulus($sformatf("random%0d", r), r % 3, 0, 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
